// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - frame sequencer for the 6-tap FIR datapath (optional FIR_SEQ_CTRL_WARMUP_EN adds primed)
module fir_seq_ctrl #(
    parameter int bits_I = 3,
    parameter int N_TAPS = 6,
    parameter int CW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [bits_I-1:0] sel,
    output logic [CW-1:0]     coef_addr,
    output logic              load_x,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              shift_en,
    output logic              busy
`ifdef FIR_SEQ_CTRL_WARMUP_EN
    ,
    output logic              primed
`endif
);

    // Frame phases: clear the MAC, walk the taps oldest to newest, hand
    // the result over, then advance the delay line.
    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
        OUT,
        SHIFT
    } state_t;

    localparam logic [bits_I-1:0] ONE  = bits_I'(1);
    localparam logic [bits_I-1:0] LAST = bits_I'(N_TAPS);

    state_t            state;
    logic [bits_I-1:0] cnt;
    logic              idle_q;

    // in_ready must read low while rst is held, even though the registered
    // idle flag already sits at its reset value of 1.
    assign in_ready = idle_q & ~rst;

    // The sample is latched on the accept cycle itself, so load_x is the
    // raw handshake; in_ready already restricts it to IDLE.
    assign load_x = in_valid & in_ready;

    // Sequencer state, tap counter and all registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idle_q    <= 1'b1;
            busy      <= 1'b0;
            sel       <= '0;
            coef_addr <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            shift_en  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= CLR;
                        idle_q  <= 1'b0;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                    end
                end

                CLR: begin
                    // First accumulate cycle addresses the oldest tap.
                    state     <= ACC;
                    cnt       <= ONE;
                    sel       <= ONE;
                    coef_addr <= '0;
                    mac_clr   <= 1'b0;
                    mac_en    <= 1'b1;
                end

                ACC: begin
                    if (cnt == LAST) begin
                        // Newest tap has been accumulated: park the mux at 0.
                        state     <= OUT;
                        cnt       <= '0;
                        sel       <= '0;
                        coef_addr <= '0;
                        mac_en    <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt       <= cnt + ONE;
                        sel       <= cnt + ONE;
                        coef_addr <= cnt[CW-1:0];
                    end
                end

                OUT: begin
                    // Result held for as long as the consumer stalls.
                    if (out_ready) begin
                        state     <= SHIFT;
                        out_valid <= 1'b0;
                        shift_en  <= 1'b1;
                    end
                end

                SHIFT: begin
                    state    <= IDLE;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                    idle_q   <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIR_SEQ_CTRL_WARMUP_EN
    localparam logic [bits_I-1:0] WSAT = bits_I'(N_TAPS - 1);

    logic [bits_I-1:0] wcnt;

    // Counts delay-line shifts until every register behind the input holds
    // a real sample; results from then on are flagged as primed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt   <= '0;
            primed <= 1'b0;
        end else if (shift_en) begin
            if (wcnt != WSAT) begin
                wcnt <= wcnt + ONE;
            end
            if ((wcnt + ONE) >= WSAT) begin
                primed <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - scoreboard bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

    localparam int N = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic [2:0] coef_addr;
    logic       load_x;
    logic       mac_clr;
    logic       mac_en;
    logic       out_valid;
    logic       out_ready;
    logic       shift_en;
    logic       busy;
`ifdef FIR_SEQ_CTRL_WARMUP_EN
    logic       primed;
`endif

    fir_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .coef_addr (coef_addr),
        .load_x    (load_x),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .shift_en  (shift_en),
        .busy      (busy)
`ifdef FIR_SEQ_CTRL_WARMUP_EN
        ,
        .primed    (primed)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state: expected event cycles per accepted frame.
    int exp_clr[$];
    int exp_acc_cyc[$];
    int exp_acc_sel[$];
    int exp_out[$];
    int exp_shift[$];
    bit active = 0;
    bit outv_pend = 0;
    int wcount = 0;
    int accepts = 0;

    // Raw DUT event counts for the directed frame-count checks.
    int dut_loads = 0;
    int dut_shifts = 0;
    int dut_hs = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: wait expired", name, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: derive this cycle's expected outputs from the queues and compare.
    initial forever begin
        bit e_clr, e_acc, e_shift;
        int e_sel;
        @(negedge clk);
        if (rst) begin
            chk("in_ready_in_rst", int'(in_ready), 0);
            exp_clr.delete();
            exp_acc_cyc.delete();
            exp_acc_sel.delete();
            exp_out.delete();
            exp_shift.delete();
            active = 0;
            outv_pend = 0;
            wcount = 0;
        end else begin
            e_clr = 0; e_acc = 0; e_shift = 0; e_sel = 0;
            if (exp_clr.size() > 0 && exp_clr[0] == cyc) begin
                e_clr = 1;
                void'(exp_clr.pop_front());
            end
            if (exp_acc_cyc.size() > 0 && exp_acc_cyc[0] == cyc) begin
                e_acc = 1;
                void'(exp_acc_cyc.pop_front());
                e_sel = exp_acc_sel.pop_front();
            end
            if (exp_out.size() > 0 && exp_out[0] == cyc) begin
                outv_pend = 1;
                void'(exp_out.pop_front());
            end
            if (exp_shift.size() > 0 && exp_shift[0] == cyc) begin
                e_shift = 1;
                void'(exp_shift.pop_front());
            end

            chk("mac_clr", int'(mac_clr), int'(e_clr));
            chk("mac_en", int'(mac_en), int'(e_acc));
            chk("sel", int'(sel), e_sel);
            if (e_acc) chk("coef_addr", int'(coef_addr), e_sel - 1);
            chk("out_valid", int'(out_valid), int'(outv_pend));
            chk("shift_en", int'(shift_en), int'(e_shift));
            chk("in_ready", int'(in_ready), int'(!active));
            chk("busy", int'(busy), int'(active));
            chk("load_x", int'(load_x), int'(in_valid && !active));
`ifdef FIR_SEQ_CTRL_WARMUP_EN
            chk("primed", int'(primed), int'(wcount >= N - 1));
`endif
            if (load_x) dut_loads++;
            if (shift_en) dut_shifts++;
            if (out_valid && out_ready) dut_hs++;

            if (in_valid && !active) begin
                accepts++;
                active = 1;
                exp_clr.push_back(cyc + 1);
                for (int i = 1; i <= N; i++) begin
                    exp_acc_cyc.push_back(cyc + 1 + i);
                    exp_acc_sel.push_back(i);
                end
                exp_out.push_back(cyc + 2 + N);
            end
            if (outv_pend && out_ready) begin
                outv_pend = 0;
                exp_shift.push_back(cyc + 1);
            end
            if (e_shift) begin
                active = 0;
                if (wcount < N - 1) wcount++;
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic accept_one();
        int a0;
        bit ok;
        a0 = accepts;
        ok = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (accepts != a0) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) fail("accept_timeout");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (!active && exp_shift.size() == 0 && exp_out.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("idle_timeout");
    endtask

    initial begin
        int l0, s0, h0;
        bit ok;
        in_valid = 1'b0;
        out_ready = 1'b1;
        do_reset(2);

        // Single frame, consumer always ready.
        @(posedge clk);
        #1;
        accept_one();
        wait_idle();

        // Backpressure: hold out_ready low for 5 cycles of out_valid.
        out_ready = 1'b0;
        accept_one();
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("out_valid_timeout");
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // in_valid held high: one accept per 10 cycles.
        l0 = dut_loads; s0 = dut_shifts; h0 = dut_hs;
        in_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        chk("cont_loads", dut_loads - l0, 3);
        chk("cont_shifts", dut_shifts - s0, 3);
        chk("cont_handshakes", dut_hs - h0, 3);

        // Random source and consumer behaviour.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of accumulation at sel=3.
        s0 = dut_shifts;
        accept_one();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (sel == 3'd3) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) fail("sel3_timeout");
        do_reset(1);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_shift", dut_shifts - s0, 0);

        // Six back-to-back frames from a fresh reset.
        do_reset(2);
        l0 = dut_loads;
        in_valid = 1'b1;
        repeat (60) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        chk("warm_loads", dut_loads - l0, 6);
`ifdef FIR_SEQ_CTRL_WARMUP_EN
        chk("primed_final", int'(primed), 1);
`endif

        chk("drain_acc", exp_acc_cyc.size(), 0);
        chk("drain_clr", exp_clr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer for the 6-tap FIR datapath: drives the tap-mux selector, MAC clear/accumulate strobes, coefficient address and delay-line shift.
- Sits between the sample source (valid/ready), the tap mux + MAC + delay-line registers, and the result consumer (valid/ready).
- Processes one sample per frame: clear MAC, walk all taps oldest-to-newest, present result, then shift the delay line.

Parameters:
- bits_I, 3, width of the tap-mux selector `sel`.
- N_TAPS, 6, taps per frame; legal range 1 .. 2**bits_I-1.
- CW, $clog2(N_TAPS) (min 1), coefficient-address width.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  new sample present on the datapath DATTA bus.
- in_ready  out  1  controller can accept a sample.
- sel  out  bits_I  tap-mux selector: 1 = oldest (X(k-5)) .. N_TAPS = newest (DATTA); 0 = idle, mux outputs 0.
- coef_addr  out  CW  coefficient ROM address, equal to sel-1 while accumulating.
- load_x  out  1  one-cycle pulse: latch DATTA into the input holding register.
- mac_clr  out  1  one-cycle pulse: clear the accumulator.
- mac_en  out  1  accumulate the current mux output times the coefficient.
- out_valid  out  1  accumulator holds a finished result.
- out_ready  in  1  consumer takes the result.
- shift_en  out  1  one-cycle pulse: shift the delay line (REGn <= REGn-1, REG1 <= held X).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: in_ready=0 during rst, then 1 in IDLE; all other outputs 0. State=IDLE, tap counter=0.
- Reset mid-operation:
  - Abort immediately; next cycle the block is in IDLE with reset outputs.
  - No shift_en is issued; no partial out_valid is produced.
- States: IDLE, CLR, ACC, OUT, SHIFT.
- IDLE:
  - in_ready=1, sel=0.
  - On in_valid&in_ready: assert load_x in the same cycle, go to CLR.
- CLR:
  - mac_clr=1 for one cycle; load tap counter with 1.
  - Go to ACC.
- ACC:
  - sel=counter, coef_addr=counter-1, mac_en=1.
  - Counter increments each cycle.
  - When counter==N_TAPS: go to OUT, counter cleared to 0.
  - Duration is exactly N_TAPS cycles.
- OUT:
  - out_valid=1, sel=0, mac_en=0.
  - Hold until out_ready=1; backpressure is unbounded.
  - On the handshake cycle go to SHIFT.
- SHIFT:
  - shift_en=1 for one cycle, out_valid=0.
  - Return to IDLE.
- Only one of {mac_clr, mac_en, shift_en} is high in any cycle. load_x appears only in IDLE.
- Latency:
  - Accept at cycle T → mac_clr at T+1 → mac_en at T+2..T+1+N_TAPS → out_valid from T+2+N_TAPS.
  - With out_ready held high: shift_en at T+3+N_TAPS, in_ready at T+4+N_TAPS.
  - Minimum frame is N_TAPS+4 cycles (10 at default).
- in_valid while busy is ignored (in_ready=0); the source must hold the sample.
- out_ready while out_valid=0 has no effect.
- Selector sequence per frame at default: 1,2,3,4,5,6. Values 7 and 0 are never driven during ACC.

Optional Feature:
- Macro: FIR_SEQ_CTRL_WARMUP_EN.
- Defined:
  - Adds output `primed` (1 bit, reset 0) and a saturating shift counter (reset 0, increments on each shift_en, saturates at N_TAPS-1).
  - primed=1 once the counter reaches N_TAPS-1, i.e. the delay line holds only real samples.
  - primed only flags results; the frame sequence is unchanged.
  - rst clears counter and primed.
- Not defined: the `primed` port and the counter do not exist; behaviour is otherwise identical.

Test Plan:
- rst=1 for 2 cycles, then release → in_ready=1, busy=0, sel=0, all strobes 0. Assert rst mid-ACC at sel=3 → next cycle IDLE, no shift_en, no out_valid.
- Single frame, out_ready=1: in_valid at T=0 →
  - load_x@0, mac_clr@1;
  - sel=1..6 with coef_addr=0..5 and mac_en=1 @2..7;
  - out_valid@8, shift_en@9, in_ready@10.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises → out_valid held 5 cycles, sel=0, no shift_en; out_ready=1 → shift_en the next cycle.
- in_valid held high continuously → exactly one accept per 10 cycles; in_ready=0 throughout busy; 3 frames produce 3 out_valid handshakes and 3 shift_en pulses.
- Strobe exclusivity: over 4 frames, mac_clr/mac_en/shift_en are never concurrently high, and sel never equals 0 or 7 while mac_en=1.
- WARMUP_EN defined: 6 back-to-back frames → primed=0 after frames 1-4, primed=1 after the 5th shift_en, and stays 1 through frame 6.
